// File: rtl/vga_apb_pkg.sv
// Shared definitions for the APB blocks of the VGA subsystem:
// transfer FSM encoding and default bus widths.
package vga_apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cfg_master.sv
// Single-outstanding APB requester: turns one command into one SETUP/ACCESS
// transfer and returns a response, with a bounded wait on pready.
module apb_cfg_master
  import vga_apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [DATA_WIDTH-1:0] prdata_i
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

  apb_state_e            state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          pwrite_d = cmd_write_i;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over an expiring timeout in the same cycle
        if (pready_i) begin
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pwrite_o    = pwrite_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master: vector table of single transfers plus
// hand sequences for response backpressure and reset during ACCESS.
module tb_apb_cfg_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_wdata_i = '0;
  logic          rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o, prdata_i = '0;
  logic          psel_o, penable_o, pwrite_o;
  logic          pready_i = 1'b0, pslverr_i = 1'b0;

  always #5 clk = ~clk;

  apb_cfg_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    logic          slverr;
    int            delay;     // ACCESS cycles with pready low before pready high
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_acc;   // expected number of ACCESS cycles
  } vec_t;

  vec_t vecs[6];

  // Issue one command at the next negedge and return once it is in SETUP.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input string nm);
    @(negedge clk);
    chk({nm, " cmd_ready idle"}, cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = d;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_addr_i = '1; cmd_wdata_i = '1; cmd_write_i = ~wr;
    chk({nm, " setup psel/pen/ready"}, {psel_o, penable_o, cmd_ready_o}, 3'b100);
    chk({nm, " setup paddr"}, paddr_o, a);
    chk({nm, " setup pwdata/pwrite"}, {pwdata_o, pwrite_o}, {d, wr});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    acc, lat;
    bit    done, bad;
    string nm;
    nm = $sformatf("v%0d", idx);
    issue(v.wr, v.addr, v.wdata, nm);
    // completer noise during SETUP must be ignored
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hFFFF_FFFF;
    acc = 0; lat = 1; done = 0; bad = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o) done = 1;
      else begin
        acc++;
        if (!(psel_o && penable_o) || paddr_o !== v.addr || pwrite_o !== v.wr ||
            pwdata_o !== v.wdata || cmd_ready_o) bad = 1;
        pready_i = (acc == v.delay + 1); pslverr_i = v.slverr; prdata_i = v.prdata;
      end
    end
    chk({nm, " response seen"}, done, 1);
    chk({nm, " access ctl stable"}, bad, 0);
    chk({nm, " access cycles"}, acc, v.exp_acc);
    chk({nm, " latency"}, lat, 2 + v.exp_acc);
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h5555_AAAA;
    chk({nm, " rdata"}, rsp_rdata_o, v.exp_rdata);
    chk({nm, " err"}, rsp_err_o, v.exp_err);
    chk({nm, " resp psel/pen/ready"}, {psel_o, penable_o, cmd_ready_o}, 3'b000);
    chk({nm, " resp paddr held"}, paddr_o, v.addr);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
    chk({nm, " idle after rsp"}, {rsp_valid_o, cmd_ready_o, psel_o}, 3'b010);
  endtask

  initial begin
    bit bad;
    //             wr    addr  wdata          prdata         err  dly  exp_rdata      exp_err acc
    vecs[0] = '{1'b1, 32'h0, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1,   32'h0,         1'b0, 2};
    vecs[1] = '{1'b0, 32'h1, 32'h0,         32'h1234_5678, 1'b0, 0,   32'h1234_5678, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h3, 32'h0,         32'hA5A5_0F0F, 1'b0, 15,  32'hA5A5_0F0F, 1'b0, 16};
    vecs[3] = '{1'b0, 32'h4, 32'h0,         32'h7777_7777, 1'b0, 255, 32'h0,         1'b1, 16};
    vecs[4] = '{1'b1, 32'h2, 32'hFACE_0001, 32'h1111_2222, 1'b1, 0,   32'h0,         1'b1, 1};
    vecs[5] = '{1'b0, 32'h5, 32'h0,         32'hCAFE_F00D, 1'b1, 3,   32'hCAFE_F00D, 1'b1, 4};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", {cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o}, 6'b100000);
    chk("reset data", {rsp_rdata_o, paddr_o}, 64'h0);
    chk("reset pwdata", pwdata_o, 0);
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // slave error on write, response held off for 5 cycles
    issue(1'b1, 32'h2, 32'h0BAD_0002, "bp");
    pready_i = 1'b1; pslverr_i = 1'b1;
    @(negedge clk);
    chk("bp access", penable_o, 1);
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      cmd_valid_i = 1'b1; cmd_addr_i = 32'h99;
      pready_i = c[0]; pslverr_i = ~c[0]; prdata_i = 32'h1357_9BDF;
      if (!rsp_valid_o || rsp_err_o !== 1'b1 || rsp_rdata_o !== '0 || cmd_ready_o || psel_o) bad = 1;
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    chk("bp stable 5 cycles", bad, 0);
    chk("bp still valid", {rsp_valid_o, rsp_err_o, cmd_ready_o}, 3'b110);
    chk("bp paddr held", paddr_o, 32'h2);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
    chk("bp idle", {rsp_valid_o, cmd_ready_o, psel_o}, 3'b010);

    // reset while in ACCESS aborts with no response
    issue(1'b0, 32'h7, 32'h0, "rst");
    @(negedge clk);
    chk("rst in access", {psel_o, penable_o}, 2'b11);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst abort ctl", {psel_o, penable_o, rsp_valid_o, rsp_err_o}, 4'b0000);
    chk("rst abort paddr", paddr_o, 0);
    resetn = 1'b1;
    pready_i = 1'b1; prdata_i = 32'h2468_ACE0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid_o || psel_o || !cmd_ready_o) bad = 1;
    end
    pready_i = 1'b0;
    chk("rst no response", bad, 0);

    // normal transfer still works after the abort
    run_vec(vecs[1], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_cfg_master.md
APB_CFG_MASTER -- requirements
Module: apb_cfg_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, APB data width; ADDR_WIDTH, default 32, APB address width; TIMEOUT, default 16, maximum ACCESS cycles before forced error (>=2).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-006 cmd_write_i  input  1  1=write, 0=read.
REQ-007 cmd_addr_i  input  ADDR_WIDTH  target register address.
REQ-008 cmd_wdata_i  input  DATA_WIDTH  write data.
REQ-009 rsp_valid_o  output  1  response available.
REQ-010 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-011 rsp_rdata_o  output  DATA_WIDTH  read data (0 for writes and on timeout).
REQ-012 rsp_err_o  output  1  pslverr_i or timeout occurred.
REQ-013 paddr_o, pwdata_o  output  ADDR_WIDTH, DATA_WIDTH  APB address/write data.
REQ-014 psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-015 pready_i, pslverr_i  input  1 each; prdata_i  input  DATA_WIDTH  APB completer response.

Function
REQ-016 FSM SHALL have states IDLE, SETUP, ACCESS, RESP; cmd_ready_o SHALL equal (state==IDLE).
REQ-017 IDLE: on cmd_valid_i, latch write/addr/wdata and go SETUP next cycle; otherwise stay.
REQ-018 SETUP: psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o driven from latched command; always go ACCESS after one cycle.
REQ-019 ACCESS: psel_o=1, penable_o=1, address/control/data held stable; stay until pready_i=1 or timeout.
REQ-020 Timeout counter SHALL clear on SETUP entry, increment each ACCESS cycle with pready_i=0; when count reaches TIMEOUT-1 with pready_i=0, end transfer with error.
REQ-021 On pready_i=1 in ACCESS: capture rsp_rdata_o=prdata_i for reads (0 for writes), rsp_err_o=pslverr_i, go RESP; pready_i and timeout in same cycle SHALL resolve as normal completion.
REQ-022 On timeout: rsp_rdata_o=0, rsp_err_o=1, go RESP.
REQ-023 Outside SETUP/ACCESS psel_o=0, penable_o=0; paddr_o/pwdata_o/pwrite_o hold last values.
REQ-024 RESP: rsp_valid_o=1 with stable rdata/err until rsp_ready_i=1, then IDLE next cycle; new commands SHALL NOT be accepted in RESP.
REQ-025 pready_i, pslverr_i, prdata_i SHALL be ignored outside ACCESS.
REQ-026 Minimum transfer latency, acceptance to rsp_valid_o: 3 cycles with pready_i high on first ACCESS cycle; minimum issue interval 4 cycles.

Reset
REQ-027 On resetn=0: state IDLE, cmd_ready_o=1 after release, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, counter=0.
REQ-028 Reset mid-transfer SHALL abort immediately; no response is produced for the aborted command.

Structure
REQ-029 FSM state encoding and APB width defaults SHALL live in shared package vga_apb_pkg, reused by all APB blocks of the VGA subsystem.
REQ-030 Single flat module; no sub-module required.

Verification
REQ-031 Write addr 0x0 data 0x8000_0000, completer pready one cycle into ACCESS -> SETUP 1 cycle, ACCESS 2 cycles, rsp_err_o=0, rsp_rdata_o=0.
REQ-032 Read addr 0x1, prdata_i=0x1234_5678, pready immediate -> rsp_valid_o 3 cycles after acceptance, rsp_rdata_o=0x1234_5678.
REQ-033 pready_i held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0.
REQ-034 pslverr_i=1 with pready_i on write addr 0x2 -> rsp_err_o=1; rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and data stable, cmd_ready_o=0 throughout.
REQ-035 resetn asserted in ACCESS -> next cycle psel_o=0, penable_o=0, rsp_valid_o=0, cmd_ready_o=1 after release.
